sha256_round_engine: RTL and testbench

SHA-256 compression engine that drives the eight per-lane hash accumulators (H1..H8).
- Takes one 512-bit message block and a 256-bit chaining value and runs the 64 SHA-256 rounds, one round per clock.
- Presents the final working variables a..h to the accumulators.
- Advances the shared `Block` phase code (0 → 1 → 2), which tells each accumulator when to add its lane word exactly once.
- Sits between the nonce/header formatter and the H1..H8 accumulator bank in the two-block Bitcoin header hash path.

---
 rtl/sha256_pkg.sv | 70 +++++++
 rtl/sha256_round_engine_if.sv | 27 ++
 rtl/sha256_msg_sched.sv | 45 ++++
 rtl/sha256_round_engine.sv | 137 +++++++++++++
 tb/tb_sha256_round_engine.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, bit functions, FSM state type and Block phase codes
// for the round engine and its message scheduler.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } engine_state_e;

    localparam logic [1:0] BLOCK_CLR = 2'd0;
    localparam logic [1:0] BLOCK_1   = 2'd1;
    localparam logic [1:0] BLOCK_2   = 2'd2;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Standard initial hash values H0..H7 (lane 1 .. lane 8).
    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// Host-side bundle of the round engine: request handshake, block data and
// the per-lane results handed to the H1..H8 accumulators.
interface sha256_round_engine_if;
    // Handshake: a request is taken on a rising edge where start=1 and ready=1;
    // start while ready=0 is ignored, and done pulses once when results update.
    logic         start;
    logic [1:0]   block_sel;
    logic [511:0] msg;
    logic [255:0] iv;
    logic         ready;
    logic [1:0]   Block;
    logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;
    logic         done;
    logic         err;

    modport master (
        output start, block_sel, msg, iv,
        input  ready, Block, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out,
        input  done, err
    );

    modport slave (
        input  start, block_sel, msg, iv,
        output ready, Block, a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out,
        output done, err
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// 16-word message-schedule window: slot 0 always holds W[t] for the current
// round, and each shift appends W[t+16] computed from the window contents.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [511:0] msg_i,
    output logic [31:0]  w_o
);

    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_next;

    always_comb begin
        w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
        win_d  = win_q;
        if (load_i) begin
            for (int i = 0; i < 16; i++) begin
                win_d[i] = msg_i[511 - 32*i -: 32];
            end
        end else if (shift_i) begin
            for (int i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign w_o = win_q[0];

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression core: runs ROUNDS rounds on one block and presents a..h
// plus the Block phase code to the H1..H8 accumulator bank (no feed-forward add).
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    sha256_round_engine_if.slave  bus,
    output engine_state_e         state_o
);

    engine_state_e state_q, state_d;
    logic [6:0]    t_q, t_d;
    logic [31:0]   work_q [8];
    logic [31:0]   work_d [8];
    logic [31:0]   out_q  [8];
    logic [31:0]   out_d  [8];
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    block_q, block_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sched_load, sched_shift;
    logic [31:0]   w_t, t1, t2;
    logic          req_legal;

    sha256_msg_sched u_sched (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sched_load),
        .shift_i (sched_shift),
        .msg_i   (bus.msg),
        .w_o     (w_t)
    );

    // work_q index 0..7 holds a..h.
    always_comb begin
        req_legal = (bus.block_sel == BLOCK_1 && block_q == BLOCK_CLR) ||
                    (bus.block_sel == BLOCK_2 && block_q == BLOCK_1);
        t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6])
           + K[t_q[5:0]] + w_t;
        t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        work_d      = work_q;
        out_d       = out_q;
        sel_d       = sel_q;
        block_d     = block_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sched_load  = 1'b0;
        sched_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (req_legal) begin
                        for (int i = 0; i < 8; i++) begin
                            work_d[i] = bus.iv[255 - 32*i -: 32];
                        end
                        sel_d      = bus.block_sel;
                        t_d        = '0;
                        sched_load = 1'b1;
                        state_d    = ST_ROUND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ROUND: begin
                sched_shift = 1'b1;
                work_d[0]   = t1 + t2;
                work_d[1]   = work_q[0];
                work_d[2]   = work_q[1];
                work_d[3]   = work_q[2];
                work_d[4]   = work_q[3] + t1;
                work_d[5]   = work_q[4];
                work_d[6]   = work_q[5];
                work_d[7]   = work_q[6];
                if (t_q == 7'(ROUNDS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + 7'd1;
                end
            end
            ST_DONE: begin
                out_d   = work_q;
                block_d = sel_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            sel_q   <= BLOCK_CLR;
            block_q <= BLOCK_CLR;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                work_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            sel_q   <= sel_d;
            block_q <= block_d;
            done_q  <= done_d;
            err_q   <= err_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.Block = block_q;
    assign bus.a_out = out_q[0];
    assign bus.b_out = out_q[1];
    assign bus.c_out = out_q[2];
    assign bus.d_out = out_q[3];
    assign bus.e_out = out_q[4];
    assign bus.f_out = out_q[5];
    assign bus.g_out = out_q[6];
    assign bus.h_out = out_q[7];
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: known-answer blocks, phase sequencing, error
// and reset behaviour, and random blocks against an array-based SHA-256 model.
module tb_sha256_round_engine;
    import sha256_pkg::*;

    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIGEST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_round_engine_if bus();
    engine_state_e dbg_state;

    sha256_round_engine #(.ROUNDS(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] outs();
        return {bus.a_out, bus.b_out, bus.c_out, bus.d_out,
                bus.e_out, bus.f_out, bus.g_out, bus.h_out};
    endfunction

    function automatic logic [255:0] lane_add(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Reference: full schedule expanded up front, then 64 rounds on an array.
    function automatic logic [255:0] ref_compress(input logic [511:0] m, input logic [255:0] v);
        logic [31:0] w [64];
        logic [31:0] s [8];
        logic [31:0] nx [8];
        logic [31:0] x1, x2, e, a;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) s[i] = v[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            e  = s[4];
            a  = s[0];
            x1 = s[7] + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & s[5]) ^ (~e & s[6]))
               + K[t] + w[t];
            x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & s[1]) ^ (a & s[2]) ^ (s[1] & s[2]));
            nx[0] = x1 + x2;
            nx[4] = s[3] + x1;
            nx[1] = s[0]; nx[2] = s[1]; nx[3] = s[2];
            nx[5] = s[4]; nx[6] = s[5]; nx[7] = s[6];
            s = nx;
        end
        return {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    function automatic logic [255:0] rand_iv();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // H1..H8 accumulator model: adds the lane words once whenever Block moves to a new nonzero phase.
    logic [255:0] acc;
    int           add_cnt;
    logic [1:0]   last_blk;
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            acc      = IV256;
            add_cnt  = 0;
            last_blk = 2'd0;
        end else if (bus.Block !== last_blk) begin
            if (bus.Block != 2'd0) begin
                acc = lane_add(acc, outs());
                add_cnt++;
            end
            last_blk = bus.Block;
        end
    end

    task automatic do_reset(input int n);
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge E0.
    task automatic issue(input logic [1:0] sel, input logic [511:0] m, input logic [255:0] v);
        bus.start     = 1'b1;
        bus.block_sel = sel;
        bus.msg       = m;
        bus.iv        = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.msg   = rand_block();
        bus.iv    = rand_iv();
    endtask

    task automatic wait_done(input int poke_at, output int lat, output int errs);
        lat  = 0;
        errs = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (lat == poke_at) begin
                bus.start     = 1'b1;
                bus.block_sel = 2'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (bus.err === 1'b1) errs++;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [1:0] sel, input logic [511:0] m,
                             input logic [255:0] v, input int poke_at);
        int lat, errs;
        exp_q.push_back(ref_compress(m, v));
        issue(sel, m, v);
        check({tag, " ready_low"}, 256'(bus.ready), 256'(0));
        wait_done(poke_at, lat, errs);
        check({tag, " done_latency"}, 256'(lat), 256'(65));
        check({tag, " no_err"}, 256'(errs), 256'(0));
        check({tag, " block"}, 256'(bus.Block), 256'(sel));
        if (exp_q.size() > 0) check({tag, " outs"}, outs(), exp_q.pop_front());
        @(negedge clk);
        check({tag, " done_pulse"}, 256'(bus.done), 256'(0));
        check({tag, " ready_back"}, 256'(bus.ready), 256'(1));
    endtask

    logic [511:0] abc_msg, two_m1, two_m2, m1, m2;
    logic [255:0] sum1, v1, v2, final_exp;
    int           n_done;

    initial begin
        bus.start     = 1'b0;
        bus.block_sel = 2'd0;
        bus.msg       = '0;
        bus.iv        = '0;
        abc_msg = {32'h61626380, 448'h0, 32'h00000018};
        two_m1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_m2  = {480'h0, 32'h000001c0};

        @(negedge clk);
        do_reset(2);
        check("rst block", 256'(bus.Block), 256'(0));
        check("rst ready", 256'(bus.ready), 256'(1));
        check("rst outs", outs(), 256'(0));
        check("rst done", 256'(bus.done), 256'(0));
        check("rst err", 256'(bus.err), 256'(0));
        check("rst state", 256'(dbg_state), 256'(ST_IDLE));

        // Illegal requests from the cleared phase.
        issue(2'd2, abc_msg, IV256);
        check("seq2 err", 256'(bus.err), 256'(1));
        check("seq2 ready", 256'(bus.ready), 256'(1));
        check("seq2 block", 256'(bus.Block), 256'(0));
        @(negedge clk);
        check("seq2 err_pulse", 256'(bus.err), 256'(0));
        issue(2'd3, abc_msg, IV256);
        check("sel3 err", 256'(bus.err), 256'(1));
        check("sel3 ready", 256'(bus.ready), 256'(1));
        check("sel3 block", 256'(bus.Block), 256'(0));
        @(negedge clk);

        // "abc" with a busy-time start poke during round ~10.
        run_block("abc", 2'd1, abc_msg, IV256, 10);
        check("abc digest", lane_add(IV256, outs()), ABC_DIGEST);
        check("abc acc", acc, ABC_DIGEST);

        // Block 1 done: another block-1 request is a sequence violation.
        issue(2'd1, abc_msg, IV256);
        check("seq1again err", 256'(bus.err), 256'(1));
        check("seq1again block", 256'(bus.Block), 256'(1));
        @(negedge clk);

        // Mid-operation reset at round 30 of a block-2 request.
        issue(2'd2, two_m2, IV256);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst block", 256'(bus.Block), 256'(0));
        check("midrst ready", 256'(bus.ready), 256'(1));
        check("midrst outs", outs(), 256'(0));
        check("midrst done", 256'(bus.done), 256'(0));
        n_done = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        check("midrst no_done", 256'(n_done), 256'(0));

        // rst and start together: reset must win.
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.block_sel = 2'd1;
        @(negedge clk);
        check("rst_start state", 256'(dbg_state), 256'(ST_IDLE));
        check("rst_start ready", 256'(bus.ready), 256'(1));
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start idle", 256'(dbg_state), 256'(ST_IDLE));
        check("rst_start err", 256'(bus.err), 256'(0));

        // Two-block known answer with phase tracking.
        do_reset(2);
        check("two block0", 256'(bus.Block), 256'(0));
        run_block("two_b1", 2'd1, two_m1, IV256, -1);
        sum1 = lane_add(IV256, outs());
        check("two adds1", 256'(add_cnt), 256'(1));
        run_block("two_b2", 2'd2, two_m2, sum1, -1);
        check("two digest", lane_add(sum1, outs()), TWO_DIGEST);
        check("two acc", acc, TWO_DIGEST);
        check("two adds2", 256'(add_cnt), 256'(2));
        issue(2'd2, two_m2, sum1);
        check("seq_after2 err", 256'(bus.err), 256'(1));
        check("seq_after2 block", 256'(bus.Block), 256'(2));
        @(negedge clk);

        // Random block pairs against the model and accumulator.
        for (int k = 0; k < 3; k++) begin
            do_reset(2);
            m1 = rand_block();
            m2 = rand_block();
            v1 = rand_iv();
            v2 = rand_iv();
            final_exp = lane_add(lane_add(IV256, ref_compress(m1, v1)), ref_compress(m2, v2));
            run_block($sformatf("rnd%0d_b1", k), 2'd1, m1, v1, -1);
            run_block($sformatf("rnd%0d_b2", k), 2'd2, m2, v2, $urandom_range(1, 60));
            check($sformatf("rnd%0d acc", k), acc, final_exp);
            check($sformatf("rnd%0d adds", k), 256'(add_cnt), 256'(2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
